// File: rtl/f_pc.sv
// Fetch-stage PC: sequential, branch, jump and jr next-PC selection with illegal-address flag.
// Latency: the selected next PC appears on F_PC one clock after it is presented (one-cycle redirect).
// Backpressure: stall freezes F_PC, F_fetch_cnt and F_pc_err; a redirect seen during stall is ignored.
module f_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        cmp_true,
  input  logic [31:0] D_PC,
  input  logic [25:0] D_imm,
  input  logic [31:0] jr_target,
  output logic [31:0] F_PC,
  output logic        F_pc_err,
  output logic [31:0] F_fetch_cnt
);

  localparam logic [1:0] OP_SEQ = 2'd0;
  localparam logic [1:0] OP_BR  = 2'd1;
  localparam logic [1:0] OP_J   = 2'd2;
  localparam logic [1:0] OP_JR  = 2'd3;

  // Last legal word address; arithmetic wraps at 32 bits like the datapath adders.
  localparam logic [31:0] IM_BYTES = 32'(IM_WORDS) << 2;
  localparam logic [31:0] PC_LAST  = RESET_PC + IM_BYTES - 32'd4;

  logic [31:0] pc_seq;
  logic [31:0] br_off;
  logic [31:0] npc;
  logic        npc_bad;

  assign pc_seq = F_PC + 32'd4;
  // Branch offset is relative to the delay-slot address (D_PC+4), in words.
  assign br_off = {{14{D_imm[15]}}, D_imm[15:0], 2'b00};

  // Select the next fetch address from the D-stage redirect kind.
  always_comb begin
    npc = pc_seq;
    case (npc_op)
      OP_SEQ: npc = pc_seq;
      OP_BR:  npc = cmp_true ? (D_PC + 32'd4 + br_off) : pc_seq;
      OP_J:   npc = {D_PC[31:28], D_imm, 2'b00};
      OP_JR:  npc = jr_target;
      default: npc = pc_seq;
    endcase
  end

  // Illegal: misaligned or outside the instruction memory window.
  always_comb begin
    npc_bad = (npc[1:0] != 2'b00) || (npc < RESET_PC) || (npc > PC_LAST);
  end

  // PC, fetch counter and sticky error update; reset beats stall beats load.
  always_ff @(posedge clk) begin
    if (reset) begin
      F_PC        <= RESET_PC;
      F_pc_err    <= 1'b0;
      F_fetch_cnt <= 32'd0;
    end else if (!stall) begin
      F_PC        <= npc;
      F_fetch_cnt <= F_fetch_cnt + 32'd1;
      if (npc_bad) begin
        F_pc_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/f_pc.md
# f_pc

Fetch-stage program counter and next-PC unit of the five-stage pipelined MIPS core. It holds the fetch address presented to the instruction memory every cycle. It selects the next address from three sources: sequential increment, taken branch, and absolute/register jump, all resolved in D with a one-instruction delay slot. It honours pipeline stalls and flags illegal fetch addresses.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset; base of instruction memory
- IM_WORDS, 4096, instruction memory depth in words; legal range is RESET_PC .. RESET_PC+4*IM_WORDS-4

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit freeze of F and D; PC holds
- npc_op  in  2  D-stage next-PC kind: 0 sequential, 1 branch, 2 j/jal, 3 jr
- cmp_true  in  1  D-stage branch comparator result; only meaningful when npc_op=1
- D_PC  in  32  PC of the instruction currently in D
- D_imm  in  26  D-stage instruction bits [25:0]
- jr_target  in  32  forwarded rs value for jr/jalr
- F_PC  out  32  current fetch address, registered
- F_pc_err  out  1  sticky flag: an illegal next PC was loaded
- F_fetch_cnt  out  32  count of cycles in which the PC advanced

## Operation
- Next-PC candidate, combinational:
  - npc_op=0, or npc_op=1 with cmp_true=0: F_PC+4.
  - npc_op=1 with cmp_true=1: D_PC+4+(sign_extend(D_imm[15:0])<<2).
  - npc_op=2: {D_PC[31:28], D_imm, 2'b00}.
  - npc_op=3: jr_target, used unmodified.
- All additions are 32-bit modulo 2^32. No carry out is kept.
- Delay slot: the instruction at D_PC+4 is already in F when a redirect is in D. It is not squashed. The redirect replaces the fetch that follows it.
- Update priority on each edge:
  1. reset
  2. stall
  3. load candidate
- stall=1: F_PC, F_fetch_cnt and F_pc_err hold. A redirect presented during a stall is ignored. D re-presents it after the stall releases, because D is frozen too.
- Error check, applied to the candidate being loaded:
  - Illegal means low two bits are nonzero, or the address is below RESET_PC, or above RESET_PC+4*IM_WORDS-4.
  - An illegal candidate is still loaded into F_PC, and F_pc_err sets to 1.
  - F_pc_err stays 1 until reset.
- F_fetch_cnt increments by 1 on every non-stalled, non-reset edge. It wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values: F_PC=RESET_PC, F_pc_err=0, F_fetch_cnt=0.
- Reset is synchronous. It acts only on a rising edge with reset=1, and overrides stall and any redirect.
- Reset asserted mid-stream discards any pending redirect. The first fetch after reset deasserts is RESET_PC.
- F_PC changes only at clock edges. Instruction memory read is combinational on F_PC, so the instruction is available in the same cycle.
- Redirect latency: one cycle. A taken branch in D during cycle n gives F_PC = target in cycle n+1, assuming stall=0 at the n edge.
- Simultaneous stall and redirect: stall wins. The target loads on the first edge with stall=0 while D still holds the redirect.
- Back-to-back redirects, e.g. jr whose delay slot is j: each is resolved independently when it reaches D. The last one resolved determines the fetch.
- Error detection is not delayed. F_pc_err rises on the same edge that loads the illegal F_PC.

## Test plan
- Reset then 3 free-running cycles.
  - F_PC: 3000 → 3004 → 3008 → 300C.
  - F_fetch_cnt=3.
  - F_pc_err=0.
- Branch, F_PC=3008 with npc_op=1, cmp_true=1, D_PC=3004, D_imm[15:0]=16'hFFFE:
  - Next F_PC=3004+4-8=3000.
  - Repeat with cmp_true=0: next F_PC=300C.
- j: D_PC=3010, D_imm=26'h0000C10 → next F_PC=00003040. jr: jr_target=32'h0000_3100 → next F_PC=3100, F_pc_err=0.
- Stall with redirect:
  - stall=1 for 2 cycles with npc_op=2 held → F_PC and F_fetch_cnt unchanged.
  - stall drops → target loaded on the next edge.
- Illegal address:
  - jr_target=32'h0000_3102 → F_PC=3102, F_pc_err=1.
  - Next PC sequential → F_pc_err stays 1.
  - Separately, target 32'h0000_7000 with IM_WORDS=4096 → F_pc_err=1.
  - Reset → F_pc_err=0, F_PC=3000.
- Reset with stall=1 and npc_op=3 asserted on the same edge → F_PC=3000, F_fetch_cnt=0.
